cla_seq_adder: RTL and testbench
================================

# cla_seq_adder

Multi-cycle wide adder/subtractor that time-shares one narrow carry-lookahead slice, built from the team's basic propagate/generate/sum cells, across all slices of a wide operand. It latches an operation on a valid/ready input handshake, runs one slice per clock from LSB to MSB, and threads the carry through a register. It then presents sum, carry-out and signed overflow on a valid/ready output handshake. It sits between the datapath issue logic and the result writeback, where area matters more than single-cycle latency.

## Interface
- SLICE_W, 4, bits processed per cycle (width of the shared slice)
- NUM_SLICES, 4, slices per operation; operand width W = SLICE_W*NUM_SLICES
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  requester presents an operation
- in_ready  out  1  block can accept an operation
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry-in (ignored when in_sub=1)
- in_sub  in  1  1 = A minus B
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- out_sum  out  W  result
- out_cout  out  1  carry-out of MSB slice
- out_ovf  out  1  signed overflow
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch A into the A register.
  - Latch B into the B register, inverted bitwise if in_sub.
  - Load the carry register with 1 if in_sub, else in_cin.
  - Clear slice index, clear the sum register, then go to RUN.
- RUN: each cycle, the slice at the current index gets A/B bits [idx*SLICE_W +: SLICE_W] and the carry register.
  - The slice sum is written to the same bits of the sum register.
  - The slice carry-out is written to the carry register.
  - idx increments.
  - When idx==NUM_SLICES-1, capture cout and compute ovf, then go to DONE.
- Overflow: ovf = carry into the MSB bit XOR carry out of the MSB bit. The slice exports the carry into its top bit for this.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are stable.
  - On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid there is ignored and not queued.
- out_valid is asserted only in DONE. Outputs keep their last values in IDLE and RUN, but are meaningful only while out_valid=1.
- All arithmetic is modulo 2^W. There is no saturation.

## Timing
- Reset (async assert, sync deassert) takes effect immediately:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_cout=0, out_ovf=0, idx=0, carry register=0.
- Reset mid-operation aborts the operation and produces no result.
- Latency: accept at edge T, out_valid=1 from edge T+NUM_SLICES.
- Throughput: one operation per NUM_SLICES+1 cycles with out_ready tied high. The DONE->IDLE cycle is not overlapped with a new accept.
- Backpressure: with out_ready=0, DONE holds indefinitely and the outputs do not change.
- in_valid and out_ready are never acted on in the same cycle (they are valid in different states), so simultaneous events need no priority rule.
- NUM_SLICES=1 is legal: IDLE -> RUN for 1 cycle -> DONE.

## Structure
- Package cla_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default SLICE_W and NUM_SLICES;
  - the index width, clog2(NUM_SLICES), minimum 1.
- Sub-module cla_slice is purely combinational:
  - a SLICE_W chain of basic cells with lookahead carry from the p/g outputs;
  - outputs slice sum, slice cout and carry into the top bit.
- Top level holds the FSM, operand/sum/carry registers and the handshake logic.

## Test plan
- 0xFFFF + 0x0001, cin=0, sub=0 (default params) -> out_valid 4 cycles after accept; sum 0x0000, cout 1, ovf 0.
- 0x0005 - 0x0007, sub=1 -> sum 0xFFFE, cout 0, ovf 0. Then 0x8000 - 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
- 0x7FFF + 0x0001 -> sum 0x8000, ovf 1. Then 0x1234 + 0x0FED, cin=1 -> sum 0x2222, cout 0.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, outputs constant, in_ready 0; release -> IDLE next cycle, in_ready 1.
- in_valid pulsed during RUN with different operands -> ignored; result matches the first operation only.
- Assert rst_n=0 during RUN slice 2 -> out_valid 0, busy 0 immediately; after release, a new operation completes correctly with no residue from the aborted one.

Source files
------------

// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the time-shared carry-lookahead adder:
// FSM state encoding, default geometry and the slice-index width helper.
package cla_seq_pkg;

    localparam int SLICE_W_DEF    = 4;
    localparam int NUM_SLICES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width; a single-slice build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NUM_SLICES_DEF);

endpackage

// File: rtl/cla_seq_adder_if.sv
// Request/response bundle between the issue logic (master) and the adder (slave).
interface cla_seq_adder_if
    import cla_seq_pkg::*;
#(
    parameter int W = SLICE_W_DEF * NUM_SLICES_DEF
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/cla_seq_adder_slice.sv
// Combinational SLICE_W-bit carry-lookahead slice built from per-bit
// propagate/generate/sum cells. Also exports the carry into the top bit so
// the caller can derive signed overflow on the most significant slice.
module cla_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c_top
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    // Basic cells: propagate, generate and sum per bit.
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_cell
        assign p[gi]   = a[gi] ^ b[gi];
        assign g[gi]   = a[gi] & b[gi];
        assign sum[gi] = p[gi] ^ c[gi];
    end

    // Lookahead carries as flat sum-of-products of p/g and cin (no ripple).
    always_comb begin
        logic acc;
        logic term;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i <= SLICE_W; i++) begin
            acc = cin;
            for (int j = 0; j < i; j++) begin
                acc = acc & p[j];
            end
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign cout  = c[SLICE_W];
    assign c_top = c[SLICE_W-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle W-bit adder/subtractor: one shared lookahead slice is applied
// LSB-first, one slice per clock, with the carry threaded through a register.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = NUM_SLICES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_adder_if.slave bus,
    output logic           busy
);

    localparam int W     = SLICE_W * NUM_SLICES;
    localparam int IDX_W = idx_width(NUM_SLICES);

    state_t state_reg;
    state_t state_next;

    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [SLICE_W-1:0] sum_sl_reg [NUM_SLICES];
    logic [W-1:0]       sum_packed;

    logic [SLICE_W-1:0] a_sl [NUM_SLICES];
    logic [SLICE_W-1:0] b_sl [NUM_SLICES];
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_c_top;

    logic in_ready_c;
    logic out_valid_c;
    logic busy_c;
    logic accept;
    logic run;
    logic last;

    assign accept = (state_reg == IDLE) && bus.in_valid;
    assign run    = (state_reg == RUN);
    assign last   = (idx_reg == IDX_W'(NUM_SLICES - 1));

    // Operand slicing and result packing; the index picks the active slice.
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_lane
        assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
        assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        assign sum_packed[gi*SLICE_W +: SLICE_W] = sum_sl_reg[gi];
    end

    cla_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a     (a_sl[idx_reg]),
        .b     (b_sl[idx_reg]),
        .cin   (carry_reg),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_top (slice_c_top)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, carry thread, slice index and final flag capture.
    // Subtraction is A + ~B + 1, so B is inverted and the carry preset here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_reg <= bus.in_sub ? 1'b1 : bus.in_cin;
            idx_reg   <= '0;
        end else if (run) begin
            carry_reg <= slice_cout;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (last) begin
                cout_reg <= slice_cout;
                ovf_reg  <= slice_c_top ^ slice_cout;
            end
        end
    end

    // Per-slice sum storage: cleared on accept, written when its slice runs.
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_sum
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_sl_reg[gi] <= '0;
            end else if (accept) begin
                sum_sl_reg[gi] <= '0;
            end else if (run && (idx_reg == IDX_W'(gi))) begin
                sum_sl_reg[gi] <= slice_sum;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = sum_packed;
    assign bus.out_cout  = cout_reg;
    assign bus.out_ovf   = ovf_reg;
    assign busy          = busy_c;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: directed cases with literal results, then random
// operations compared against an integer-arithmetic model.
module tb_cla_seq_adder;

    localparam int SW = 4;
    localparam int NS = 4;
    localparam int W  = SW * NS;

    logic clk;
    logic rst_n;
    logic busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [17:0] exp_q [$];

    cla_seq_adder_if #(.W(W)) bus ();

    cla_seq_adder #(
        .SLICE_W    (SW),
        .NUM_SLICES (NS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int ua, ub, us, sa, sb, ss;
        logic co, ov;
        logic [15:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            us = ua - ub;
            ss = sa - sb;
            co = (ua >= ub);
        end else begin
            us = ua + ub + int'(cin);
            ss = sa + sb + int'(cin);
            co = (us > 65535);
        end
        s  = us[15:0];
        ov = (ss > 32767) || (ss < -32768);
        return {ov, co, s};
    endfunction

    // Every cycle: handshake consistency, and result vs. the oldest expected op.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_vs_in_ready", 32'(busy), 32'(!bus.in_ready));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(bus.out_valid), 32'(0));
                end else begin
                    check("out_sum", 32'(bus.out_sum), 32'(exp_q[0][15:0]));
                    check("out_cout", 32'(bus.out_cout), 32'(exp_q[0][16]));
                    check("out_ovf", 32'(bus.out_ovf), 32'(exp_q[0][17]));
                    check("in_ready_in_done", 32'(bus.in_ready), 32'(0));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Issue one operation (inputs driven 1 time unit after posedge), wait for
    // the result, optionally hold it under backpressure, then confirm return to IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input int bp, input bit pulse,
                          output logic [17:0] got);
        int  acc;
        bit  ok;
        got = 'x;
        ok  = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'(1));
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.out_ready = (bp == 0);
        @(posedge clk);
        exp_q.push_back(model(a, b, cin, sub));
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
        if (pulse) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            bus.in_cin   = 1'($urandom);
            bus.in_sub   = 1'($urandom);
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            check("out_valid_timeout", 32'(bus.out_valid), 32'(1));
            bus.out_ready = 1'b1;
            return;
        end
        check("latency", 32'(cyc - acc), 32'(NS));
        got = {bus.out_ovf, bus.out_cout, bus.out_sum};
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check("bp_out_valid", 32'(bus.out_valid), 32'(1));
                check("bp_in_ready", 32'(bus.in_ready), 32'(0));
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'(0));
        check("idle_in_ready", 32'(bus.in_ready), 32'(1));
        check("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [17:0] got;
        logic [17:0] m;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_sum", 32'(bus.out_sum), 32'(0));
        check("rst_out_cout", 32'(bus.out_cout), 32'(0));
        check("rst_out_ovf", 32'(bus.out_ovf), 32'(0));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the model on hand-computed results.
        m = model(16'hFFFF, 16'h0001, 1'b0, 1'b0); check("model_ffff_plus_1", 32'(m), 32'h10000);
        m = model(16'h0005, 16'h0007, 1'b0, 1'b1); check("model_5_minus_7", 32'(m), 32'h0FFFE);
        m = model(16'h8000, 16'h0001, 1'b0, 1'b1); check("model_8000_minus_1", 32'(m), 32'h37FFF);
        m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0); check("model_7fff_plus_1", 32'(m), 32'h28000);
        m = model(16'h1234, 16'h0FED, 1'b1, 1'b0); check("model_1234_0fed_c1", 32'(m), 32'h02222);

        // Directed cases with literal results.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0, got); check("dut_ffff_plus_1", 32'(got), 32'h10000);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0, got); check("dut_5_minus_7", 32'(got), 32'h0FFFE);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0, got); check("dut_8000_minus_1", 32'(got), 32'h37FFF);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0, got); check("dut_7fff_plus_1", 32'(got), 32'h28000);
        run_op(16'h1234, 16'h0FED, 1'b1, 1'b0, 0, 0, got); check("dut_1234_0fed_c1", 32'(got), 32'h02222);

        // Backpressure for 10 cycles, then in_valid pulsed during RUN.
        run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 10, 0, got); check("dut_bp_result", 32'(got), 32'h10000);
        run_op(16'h4321, 16'h1111, 1'b0, 1'b1, 0, 1, got); check("dut_pulse_result", 32'(got), 32'h13210);

        // Reset while slice 2 is being processed.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'hDEAD;
        bus.in_b     = 16'hBEEF;
        bus.in_cin   = 1'b1;
        bus.in_sub   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_out_valid", 32'(bus.out_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_in_ready", 32'(bus.in_ready), 32'(1));
        check("abort_out_sum", 32'(bus.out_sum), 32'(0));
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 0, got); check("dut_after_abort", 32'(got), 32'h01000);

        // Random operations.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (n % 8 == 0) ra = 16'h8000;
            if (n % 8 == 1) rb = 16'hFFFF;
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), got);
            $display("op %0d: a=0x%04h b=0x%04h cin=%0d sub=%0d -> sum=0x%04h cout=%0d ovf=%0d",
                     n, ra, rb, rc, rs, got[15:0], got[16], got[17]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
